// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its read-side sequencer.
// Holds the instruction word layout, address/operand/result widths and the
// reader FSM state encoding.
package instr_register_pkg;

    // Number of register entries and the width of a transfer length field.
    localparam int READER_DEPTH = 32;
    localparam int READER_CNT_W = 6;
    localparam int ERR_CNT_W    = 8;

    typedef enum logic [2:0] {
        ZERO  = 3'd0,
        PASSA = 3'd1,
        PASSB = 3'd2,
        ADD   = 3'd3,
        SUB   = 3'd4,
        MULT  = 3'd5,
        DIV   = 3'd6,
        MOD   = 3'd7
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic signed [63:0] result_t;
    typedef logic        [4:0]  address_t;

    typedef struct packed {
        opcode_t  opcode;
        operand_t operand_a;
        operand_t operand_b;
        result_t  result;
    } instruction_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_LAT  = 3'd2,
        ST_HOLD = 3'd3,
        ST_FIN  = 3'd4
    } reader_state_t;

    // Limit a requested transfer length to the number of entries present,
    // so a single request never revisits an entry.
    function automatic logic [READER_CNT_W-1:0] clamp_count(
        input logic [READER_CNT_W-1:0] req,
        input int                      depth
    );
        logic [READER_CNT_W-1:0] limit;
        limit = READER_CNT_W'(depth);
        return (req > limit) ? limit : req;
    endfunction

endpackage

// File: rtl/instr_reader_if.sv
// Output stream of the instruction reader: one captured register entry per
// valid/ready handshake, with its source address and checker verdict.
interface instr_reader_if;
    import instr_register_pkg::*;

    logic         out_valid;
    logic         out_ready;
    instruction_t out_word;
    address_t     out_addr;
    logic         chk_err;

    // Reader side drives the word, consumer side returns ready.
    modport master (
        output out_valid,
        output out_word,
        output out_addr,
        output chk_err,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_word,
        input  out_addr,
        input  chk_err,
        output out_ready
    );

endinterface

// File: rtl/instr_result_model.sv
// Combinational reference for the result an instruction should carry, used
// by the reader's optional result checker. The module only exists when the
// INSTR_READER_CHECK_EN macro is defined, so the default build carries no
// arithmetic at all.
`ifdef INSTR_READER_CHECK_EN
module instr_result_model
    import instr_register_pkg::*;
(
    input  opcode_t  opcode,
    input  operand_t operand_a,
    input  operand_t operand_b,
    output result_t  expected
);

    logic signed [63:0] a_ext;
    logic signed [63:0] b_ext;
    logic signed [31:0] quot;
    logic signed [31:0] rem;
    logic               b_zero;

    // Widen the operands first so ADD/SUB/MULT are exact in 64 bits, and
    // define division or modulo by zero as a zero result.
    always_comb begin
        a_ext  = {{32{operand_a[31]}}, operand_a};
        b_ext  = {{32{operand_b[31]}}, operand_b};
        b_zero = (operand_b == 32'sd0);
        quot   = b_zero ? 32'sd0 : (operand_a / operand_b);
        rem    = b_zero ? 32'sd0 : (operand_a % operand_b);
        expected = '0;
        case (opcode)
            ZERO:    expected = '0;
            PASSA:   expected = a_ext;
            PASSB:   expected = b_ext;
            ADD:     expected = a_ext + b_ext;
            SUB:     expected = a_ext - b_ext;
            MULT:    expected = a_ext * b_ext;
            DIV:     expected = {{32{quot[31]}}, quot};
            MOD:     expected = {{32{rem[31]}}, rem};
            default: expected = '0;
        endcase
    end

endmodule
`endif

// File: rtl/instr_reader.sv
// Read-side sequencer for the instruction register.
// On start it walks read_pointer over a run of entries (wrapping at DEPTH),
// waits out the register's one-cycle read latency, captures each entry and
// offers it on a valid/ready stream together with its source address.
// Defining INSTR_READER_CHECK_EN adds a result checker that flags entries
// whose stored result disagrees with their opcode and operands and keeps a
// saturating mismatch count; without it chk_err and err_cnt stay at 0.
module instr_reader
    import instr_register_pkg::*;
#(
    parameter int DEPTH = READER_DEPTH,
    parameter int CNT_W = READER_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  address_t             start_addr,
    input  logic [CNT_W-1:0]     count,
    output address_t             read_pointer,
    input  instruction_t         instruction_word,
    instr_reader_if.master       out_if,
    output logic                 busy,
    output logic                 done,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    reader_state_t        state_q,        state_d;
    address_t             addr_q,         addr_d;
    logic [CNT_W-1:0]     remaining_q,    remaining_d;
    address_t             read_pointer_q, read_pointer_d;
    instruction_t         out_word_q,     out_word_d;
    address_t             out_addr_q,     out_addr_d;
    logic                 out_valid_q,    out_valid_d;
    logic                 chk_err_q,      chk_err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q,      err_cnt_d;
    logic                 busy_q,         busy_d;
    logic                 done_q,         done_d;

    logic                 mismatch;
    logic                 accept;
    address_t             addr_next;

`ifdef INSTR_READER_CHECK_EN
    result_t expected_result;

    instr_result_model u_result_model (
        .opcode    (instruction_word.opcode),
        .operand_a (instruction_word.operand_a),
        .operand_b (instruction_word.operand_b),
        .expected  (expected_result)
    );

    // Verdict for the word currently on the read port; registered at capture.
    always_comb begin
        mismatch = (expected_result != instruction_word.result);
    end
`else
    // No checker: the verdict is constant, so chk_err/err_cnt flops stay 0.
    always_comb begin
        mismatch = 1'b0;
    end
`endif

    // Handshake qualifier and the wrapped successor of the current address.
    always_comb begin
        accept    = out_valid_q && out_if.out_ready;
        addr_next = (addr_q == address_t'(DEPTH - 1)) ? '0 : addr_q + 5'd1;
    end

    // Next-state and registered-output computation for the read sequence.
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        remaining_d    = remaining_q;
        read_pointer_d = read_pointer_q;
        out_word_d     = out_word_q;
        out_addr_d     = out_addr_q;
        out_valid_d    = out_valid_q;
        chk_err_d      = chk_err_q;
        err_cnt_d      = err_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        addr_d         = start_addr;
                        read_pointer_d = start_addr;
                        remaining_d    = clamp_count(count, DEPTH);
                        err_cnt_d      = '0;
                        state_d        = ST_ADDR;
                    end else begin
                        state_d = ST_FIN;
                    end
                end
            end

            ST_ADDR: begin
                state_d = ST_LAT;
            end

            ST_LAT: begin
                out_word_d  = instruction_word;
                out_addr_d  = addr_q;
                out_valid_d = 1'b1;
                chk_err_d   = mismatch;
                state_d     = ST_HOLD;
            end

            ST_HOLD: begin
                if (accept) begin
                    out_valid_d = 1'b0;
                    chk_err_d   = 1'b0;
                    if (chk_err_q && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                    remaining_d = remaining_q - 1'b1;
                    addr_d      = addr_next;
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = ST_FIN;
                    end else begin
                        read_pointer_d = addr_next;
                        state_d        = ST_ADDR;
                    end
                end
            end

            ST_FIN: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_FIN);
    end

    // State register; reset drops any in-flight word immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            addr_q         <= '0;
            remaining_q    <= '0;
            read_pointer_q <= '0;
            out_word_q     <= '0;
            out_addr_q     <= '0;
            out_valid_q    <= 1'b0;
            chk_err_q      <= 1'b0;
            err_cnt_q      <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            remaining_q    <= remaining_d;
            read_pointer_q <= read_pointer_d;
            out_word_q     <= out_word_d;
            out_addr_q     <= out_addr_d;
            out_valid_q    <= out_valid_d;
            chk_err_q      <= chk_err_d;
            err_cnt_q      <= err_cnt_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign read_pointer     = read_pointer_q;
    assign out_if.out_valid = out_valid_q;
    assign out_if.out_word  = out_word_q;
    assign out_if.out_addr  = out_addr_q;
    assign out_if.chk_err   = chk_err_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign err_cnt          = err_cnt_q;

endmodule

// File: tb/tb_instr_reader.sv
// Self-checking bench for instr_reader. A behavioural array stands in for the
// instruction register; expected streams come from a model that lists the
// addresses a request should visit and the checker verdict for each entry.
module tb_instr_reader;
    import instr_register_pkg::*;

`ifdef INSTR_READER_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    address_t     start_addr;
    logic [5:0]   count;
    address_t     read_pointer;
    instruction_t instruction_word;
    logic         busy;
    logic         done;
    logic [7:0]   err_cnt;

    instr_reader_if ifc ();

    instr_reader dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .start_addr       (start_addr),
        .count            (count),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .out_if           (ifc),
        .busy             (busy),
        .done             (done),
        .err_cnt          (err_cnt)
    );

    always #5 clk = ~clk;

    // Instruction register stand-in with a one-cycle registered read.
    instruction_t mem [32];
    always @(posedge clk) instruction_word <= mem[read_pointer];

    int n_tests = 0;
    int n_fail  = 0;

    address_t     obs_addr[$];
    instruction_t obs_word[$];
    bit           obs_chk[$];
    int           obs_k[$];
    int           first_valid_k;
    int           done_k;
    int           stab_err;
    bit           done_after;
    bit           timeout;

    address_t     exp_addr[$];
    instruction_t exp_word[$];
    bit           exp_chk[$];
    int           exp_err_cnt = 0;

    function automatic longint model_result(input opcode_t op, input int a, input int b);
        case (op)
            ZERO:    return 64'sd0;
            PASSA:   return longint'(a);
            PASSB:   return longint'(b);
            ADD:     return longint'(a) + longint'(b);
            SUB:     return longint'(a) - longint'(b);
            MULT:    return longint'(a) * longint'(b);
            DIV:     return (b == 0) ? 64'sd0 : longint'(a / b);
            MOD:     return (b == 0) ? 64'sd0 : longint'(a % b);
            default: return 64'sd0;
        endcase
    endfunction

    function automatic instruction_t rand_word();
        instruction_t w;
        int a;
        int b;
        a = int'($urandom);
        if (a == 32'h8000_0000) a = 0;
        b = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 400)) - 200;
        w.opcode    = opcode_t'($urandom_range(0, 7));
        w.operand_a = a;
        w.operand_b = b;
        if ($urandom_range(0, 1) == 0) w.result = model_result(w.opcode, a, b);
        else                           w.result = {$urandom, $urandom};
        return w;
    endfunction

    // Expected stream: consecutive addresses modulo 32, at most 32 entries.
    task automatic build_expected(input address_t sa, input int cnt);
        int n;
        int mism;
        n    = (cnt > 32) ? 32 : cnt;
        mism = 0;
        exp_addr.delete();
        exp_word.delete();
        exp_chk.delete();
        for (int i = 0; i < n; i++) begin
            address_t a;
            bit c;
            a = address_t'((int'(sa) + i) % 32);
            c = CHECK_EN && (model_result(mem[a].opcode, mem[a].operand_a, mem[a].operand_b)
                             != longint'(mem[a].result));
            exp_addr.push_back(a);
            exp_word.push_back(mem[a]);
            exp_chk.push_back(c);
            if (c) mism++;
        end
        if (n != 0) exp_err_cnt = (mism > 255) ? 255 : mism;
    endtask

    // Issue one request and record everything the stream delivers. Cycle k
    // is the k-th rising edge counting the edge that samples start as 1.
    task automatic do_transfer(input address_t sa, input logic [5:0] cnt, input int ready_pct,
                               input int hold_cycles, input int restart_k);
        int k;
        int stall_left;
        bit have_prev;
        bit rdy;
        instruction_t pw;
        address_t pa;
        address_t prp;
        bit pc;
        obs_addr.delete(); obs_word.delete(); obs_chk.delete(); obs_k.delete();
        first_valid_k = -1; done_k = -1; stab_err = 0; done_after = 1'b0; timeout = 1'b0;
        stall_left = 0; have_prev = 1'b0;
        start_addr = sa; count = cnt; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 1;
        forever begin
            if (have_prev) begin
                if (!ifc.out_valid || ifc.out_word !== pw || ifc.out_addr !== pa ||
                    ifc.chk_err !== pc || read_pointer !== prp) stab_err++;
            end
            have_prev = 1'b0;
            if (done_k >= 0 && k == done_k + 1) begin
                done_after = done;
                break;
            end
            if (done && done_k < 0) done_k = k;
            if (ifc.out_valid && first_valid_k < 0) begin
                first_valid_k = k;
                stall_left = hold_cycles;
            end
            if (k == restart_k) begin
                start = 1'b1; start_addr = ~sa; count = 6'd7;
            end else begin
                start = 1'b0;
            end
            if (stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
            end else begin
                rdy = ($urandom_range(0, 99) < ready_pct);
            end
            ifc.out_ready = rdy;
            if (ifc.out_valid && rdy) begin
                obs_addr.push_back(ifc.out_addr);
                obs_word.push_back(ifc.out_word);
                obs_chk.push_back(ifc.chk_err);
                obs_k.push_back(k);
            end else if (ifc.out_valid) begin
                have_prev = 1'b1;
                pw = ifc.out_word; pa = ifc.out_addr; pc = ifc.chk_err; prp = read_pointer;
            end
            if (k > 3000) begin
                timeout = 1'b1;
                break;
            end
            @(posedge clk); #1;
            k++;
        end
        ifc.out_ready = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; start_addr = '0; count = '0; ifc.out_ready = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = rand_word();
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({read_pointer, ifc.out_valid, ifc.out_addr, ifc.chk_err, busy, done, err_cnt} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got rp=%0d valid=%0b addr=%0d chk=%0b busy=%0b done=%0b err=%0d, expected all 0",
                     read_pointer, ifc.out_valid, ifc.out_addr, ifc.chk_err, busy, done, err_cnt);
        end
        n_tests++;
        if (ifc.out_word !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_word: got %h, expected 0", ifc.out_word);
        end
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        for (int i = 0; i < 4; i++) mem[i] = rand_word();
        build_expected(5'd0, 4);
        do_transfer(5'd0, 6'd4, 100, 0, -1);
        n_tests++;
        if (timeout || obs_addr.size() != exp_addr.size()) begin
            n_fail++;
            $display("[TB] FAIL basic_count: got %0d words (timeout=%0b), expected %0d", obs_addr.size(), timeout, exp_addr.size());
        end
        for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
            n_tests++;
            if (obs_addr[i] !== exp_addr[i] || obs_word[i] !== exp_word[i] || obs_chk[i] !== exp_chk[i]) begin
                n_fail++;
                $display("[TB] FAIL basic_word%0d: got addr=%0d word=%h chk=%0b, expected addr=%0d word=%h chk=%0b",
                         i, obs_addr[i], obs_word[i], obs_chk[i], exp_addr[i], exp_word[i], exp_chk[i]);
            end
            n_tests++;
            if (obs_k[i] !== 3 + 3 * i) begin
                n_fail++;
                $display("[TB] FAIL basic_cadence%0d: got handshake cycle %0d, expected %0d", i, obs_k[i], 3 + 3 * i);
            end
        end
        n_tests++;
        if (first_valid_k !== 3) begin
            n_fail++;
            $display("[TB] FAIL basic_latency: got first valid at cycle %0d, expected 3", first_valid_k);
        end
        n_tests++;
        if (done_k !== 13 || done_after !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL basic_done: got done at %0d (next cycle %0b), expected 13 (next cycle 0)", done_k, done_after);
        end
        n_tests++;
        if (err_cnt !== 8'(exp_err_cnt)) begin
            n_fail++;
            $display("[TB] FAIL basic_errcnt: got %0d, expected %0d", err_cnt, exp_err_cnt);
        end
    endtask

    task automatic test_wrap();
        address_t sa [2] = '{5'd30, 5'd7};
        int       cn [2] = '{4, 45};
        for (int r = 0; r < 2; r++) begin
            build_expected(sa[r], cn[r]);
            do_transfer(sa[r], 6'(cn[r]), 100, 0, -1);
            n_tests++;
            if (timeout || obs_addr.size() != exp_addr.size()) begin
                n_fail++;
                $display("[TB] FAIL wrap%0d_count: got %0d words (timeout=%0b), expected %0d", r, obs_addr.size(), timeout, exp_addr.size());
            end
            for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
                n_tests++;
                if (obs_addr[i] !== exp_addr[i] || obs_word[i] !== exp_word[i] || obs_chk[i] !== exp_chk[i]) begin
                    n_fail++;
                    $display("[TB] FAIL wrap%0d_word%0d: got addr=%0d word=%h chk=%0b, expected addr=%0d word=%h chk=%0b",
                             r, i, obs_addr[i], obs_word[i], obs_chk[i], exp_addr[i], exp_word[i], exp_chk[i]);
                end
            end
            n_tests++;
            if (err_cnt !== 8'(exp_err_cnt)) begin
                n_fail++;
                $display("[TB] FAIL wrap%0d_errcnt: got %0d, expected %0d", r, err_cnt, exp_err_cnt);
            end
        end
    endtask

    task automatic test_backpressure();
        build_expected(5'd12, 3);
        do_transfer(5'd12, 6'd3, 100, 5, -1);
        n_tests++;
        if (stab_err !== 0) begin
            n_fail++;
            $display("[TB] FAIL bp_stable: got %0d unstable stall cycles, expected 0", stab_err);
        end
        n_tests++;
        if (timeout || obs_addr.size() != 3) begin
            n_fail++;
            $display("[TB] FAIL bp_count: got %0d words (timeout=%0b), expected 3", obs_addr.size(), timeout);
        end
        for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
            n_tests++;
            if (obs_addr[i] !== exp_addr[i] || obs_word[i] !== exp_word[i]) begin
                n_fail++;
                $display("[TB] FAIL bp_word%0d: got addr=%0d word=%h, expected addr=%0d word=%h",
                         i, obs_addr[i], obs_word[i], exp_addr[i], exp_word[i]);
            end
        end
        n_tests++;
        if (obs_k.size() < 2 || obs_k[0] !== 8 || obs_k[1] !== 11) begin
            n_fail++;
            $display("[TB] FAIL bp_timing: got first handshakes at %0d,%0d, expected 8,11",
                     (obs_k.size() > 0) ? obs_k[0] : -1, (obs_k.size() > 1) ? obs_k[1] : -1);
        end
    endtask

    task automatic test_count_zero_and_ignore();
        int prev_err;
        prev_err = exp_err_cnt;
        build_expected(5'd3, 0);
        do_transfer(5'd3, 6'd0, 100, 0, -1);
        n_tests++;
        if (first_valid_k !== -1 || obs_addr.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL zero_novalid: got first valid %0d words %0d, expected none", first_valid_k, obs_addr.size());
        end
        n_tests++;
        if (done_k !== 1 || done_after !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL zero_done: got done at %0d (next %0b), expected 1 (next 0)", done_k, done_after);
        end
        n_tests++;
        if (err_cnt !== 8'(prev_err)) begin
            n_fail++;
            $display("[TB] FAIL zero_errcnt: got %0d, expected %0d", err_cnt, prev_err);
        end
        build_expected(5'd20, 2);
        do_transfer(5'd20, 6'd2, 100, 0, 2);
        n_tests++;
        if (obs_addr.size() != 2 || obs_addr[0] !== 5'd20 || obs_addr[1] !== 5'd21) begin
            n_fail++;
            $display("[TB] FAIL ignore_seq: got %0d words, expected addresses 20,21", obs_addr.size());
        end
        repeat (4) @(posedge clk);
        #1;
        n_tests++;
        if (busy !== 1'b0 || ifc.out_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL ignore_idle: got busy=%0b valid=%0b, expected 0,0", busy, ifc.out_valid);
        end
    endtask

    task automatic test_checker();
        bit want [3];
        mem[5] = '{opcode: DIV, operand_a: 32'sd12, operand_b: 32'sd3, result: 64'sd4};
        mem[6] = '{opcode: DIV, operand_a: 32'sd12, operand_b: 32'sd3, result: 64'sd36};
        mem[7] = '{opcode: MOD, operand_a: 32'sd7,  operand_b: 32'sd0, result: 64'sd0};
        want[0] = 1'b0; want[1] = CHECK_EN; want[2] = 1'b0;
        build_expected(5'd5, 3);
        do_transfer(5'd5, 6'd3, 100, 0, -1);
        n_tests++;
        if (obs_chk.size() != 3) begin
            n_fail++;
            $display("[TB] FAIL chk_count: got %0d words, expected 3", obs_chk.size());
        end
        for (int i = 0; i < obs_chk.size() && i < 3; i++) begin
            n_tests++;
            if (obs_chk[i] !== want[i] || obs_word[i] !== mem[5 + i]) begin
                n_fail++;
                $display("[TB] FAIL chk_word%0d: got chk=%0b word=%h, expected chk=%0b word=%h",
                         i, obs_chk[i], obs_word[i], want[i], mem[5 + i]);
            end
        end
        n_tests++;
        if (err_cnt !== (CHECK_EN ? 8'd1 : 8'd0)) begin
            n_fail++;
            $display("[TB] FAIL chk_errcnt: got %0d, expected %0d", err_cnt, CHECK_EN ? 1 : 0);
        end
    endtask

    task automatic test_reset_mid_hold();
        int w;
        start_addr = 5'd10; count = 6'd5; start = 1'b1; ifc.out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        w = 0;
        while (!ifc.out_valid && w < 10) begin
            @(posedge clk); #1;
            w++;
        end
        n_tests++;
        if (ifc.out_valid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL rsthold_reach: got valid=%0b after %0d cycles, expected 1", ifc.out_valid, w);
        end
        #1 reset_n = 1'b0;
        #1;
        n_tests++;
        if ({read_pointer, ifc.out_valid, ifc.out_word, ifc.out_addr, ifc.chk_err, busy, done, err_cnt} !== '0) begin
            n_fail++;
            $display("[TB] FAIL rsthold_async: got rp=%0d valid=%0b addr=%0d chk=%0b busy=%0b done=%0b err=%0d, expected all 0",
                     read_pointer, ifc.out_valid, ifc.out_addr, ifc.chk_err, busy, done, err_cnt);
        end
        exp_err_cnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        build_expected(5'd10, 3);
        do_transfer(5'd10, 6'd3, 100, 0, -1);
        n_tests++;
        if (timeout || obs_addr.size() != 3 || first_valid_k !== 3 || done_k !== 10) begin
            n_fail++;
            $display("[TB] FAIL rsthold_after: got %0d words first=%0d done=%0d, expected 3 words first=3 done=10",
                     obs_addr.size(), first_valid_k, done_k);
        end
        for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
            n_tests++;
            if (obs_addr[i] !== exp_addr[i] || obs_word[i] !== exp_word[i]) begin
                n_fail++;
                $display("[TB] FAIL rsthold_word%0d: got addr=%0d, expected addr=%0d", i, obs_addr[i], exp_addr[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            address_t sa;
            int cn;
            int want_done;
            for (int i = 0; i < 32; i++) mem[i] = rand_word();
            sa = address_t'($urandom_range(0, 31));
            cn = $urandom_range(0, 40);
            build_expected(sa, cn);
            do_transfer(sa, 6'(cn), 60, 0, -1);
            want_done = (obs_k.size() == 0) ? 1 : obs_k[obs_k.size() - 1] + 1;
            n_tests++;
            if (timeout || obs_addr.size() != exp_addr.size() || stab_err != 0) begin
                n_fail++;
                $display("[TB] FAIL rand%0d_count: got %0d words stab=%0d timeout=%0b, expected %0d words stab=0",
                         r, obs_addr.size(), stab_err, timeout, exp_addr.size());
            end
            for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
                n_tests++;
                if (obs_addr[i] !== exp_addr[i] || obs_word[i] !== exp_word[i] || obs_chk[i] !== exp_chk[i]) begin
                    n_fail++;
                    $display("[TB] FAIL rand%0d_word%0d: got addr=%0d chk=%0b, expected addr=%0d chk=%0b",
                             r, i, obs_addr[i], obs_chk[i], exp_addr[i], exp_chk[i]);
                end
            end
            n_tests++;
            if (done_k !== want_done || done_after !== 1'b0 || err_cnt !== 8'(exp_err_cnt)) begin
                n_fail++;
                $display("[TB] FAIL rand%0d_end: got done=%0d next=%0b err=%0d, expected done=%0d next=0 err=%0d",
                         r, done_k, done_after, err_cnt, want_done, exp_err_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_count_zero_and_ignore();
        test_checker();
        test_reset_mid_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_reader.md
# instr_reader

Read-side sequencer for the 32-entry instruction register. On a start pulse it walks `read_pointer` from a base address over a requested number of entries, absorbs the register's one-cycle registered read latency, and streams each captured `instruction_word` to a downstream consumer with a valid/ready handshake. It sits between the instruction register's read port and the testbench monitor/scoreboard. An optional checker recomputes each result from the stored opcode and operands.

## Interface
- `DEPTH`, 32: number of register entries; addresses wrap modulo `DEPTH`.
- `CNT_W`, 6: width of `count`, which must be able to hold `DEPTH`.
- `clk`  in  1  single clock, all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `start_addr`  in  address_t (5)  first entry to read.
- `count`  in  CNT_W  entries to read; 0 means none.
- `read_pointer`  out  address_t (5)  to the instruction register read port.
- `instruction_word`  in  instruction_t  registered read data from the instruction register.
- `out_valid`  out  1  `out_word` is valid.
- `out_ready`  in  1  consumer accepts when high with `out_valid`.
- `out_word`  out  instruction_t  captured entry: opcode, operand_a, operand_b, result.
- `out_addr`  out  address_t  address that `out_word` came from.
- `busy`  out  1  high outside IDLE.
- `done`  out  1  one-cycle pulse after the last accepted word, or after a start with `count`=0.
- `chk_err`  out  1  expected result does not match `out_word.result`; valid with `out_valid`.
- `err_cnt`  out  8  saturating mismatch count, cleared on accepted start.

## Operation
- FSM states: IDLE, ADDR, LAT, HOLD, FIN.
- IDLE
  - `start`=1 and `count`≠0: load `addr`←`start_addr` and `remaining`←`count`, clear `err_cnt`, go to ADDR.
  - `start`=1 and `count`=0: go to FIN.
- ADDR: `read_pointer`=`addr`, held stable; go to LAT.
- LAT: `instruction_word` now reflects `iw_reg[addr]`. At the end of LAT, capture it into `out_word` and `addr` into `out_addr`, then go to HOLD.
- HOLD
  - `out_valid`=1; `out_word`, `out_addr` and `chk_err` stay stable until the word is accepted.
  - On `out_ready`: decrement `remaining` and set `addr`←`addr`+1 (mod `DEPTH`, so 31 wraps to 0).
  - Go to FIN if `remaining` was 1, otherwise go to ADDR.
- FIN: assert `done` for one cycle, then go to IDLE.
- `start` outside IDLE is ignored. It is not queued.
- `count` > `DEPTH` is clamped to `DEPTH`.
- `read_pointer` holds its last value in IDLE and FIN.
- Reset (asynchronous, any state):
  - FSM goes to IDLE.
  - `read_pointer`, `out_word`, `out_addr`, `remaining` and `err_cnt` go to 0.
  - `out_valid`, `busy`, `done` and `chk_err` go to 0.
  - An in-flight word is discarded.

## Timing
- `start` is sampled at edge E0.
- ADDR occupies cycle E0–E1; LAT occupies E1–E2.
- `out_valid` first rises after E2, so start-to-first-valid latency is 3 cycles.
- With `out_ready` tied high, one word is delivered every 3 cycles.
- `done` rises in the cycle after the final handshake edge.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- Macro: `INSTR_READER_CHECK_EN`.
- With the macro defined, expected results are computed from the 32-bit signed operands `a` and `b` and compared with the 64-bit signed result field:
  - ZERO→0, PASSA→a, PASSB→b
  - ADD→a+b, SUB→a−b, MULT→a*b
  - DIV→a/b, or 0 if b=0
  - MOD→a%b, or 0 if b=0
- Comparison rules:
  - The comparison is registered at LAT capture, so `chk_err` aligns with `out_word`.
  - `err_cnt` increments by 1 on each accepted mismatching word and saturates at 255.
- Without the macro: `chk_err` and `err_cnt` are tied to 0 and no arithmetic is instantiated.

## Structure
- `instr_register_pkg` supplies:
  - `instruction_t`, `opcode_t`, `operand_t`, `result_t`, `address_t`
  - a new reader state enum `reader_state_t`
- Sub-module `instr_result_model`: combinational expected-result function of opcode and operands. It is instantiated only under `INSTR_READER_CHECK_EN`.

## Test plan
- Reset mid-HOLD: `reset_n`=0 while `out_valid`=1 → all outputs 0 immediately, FSM in IDLE; a later `start` works normally.
- Preload entries 0–3; `start_addr`=0, `count`=4, `out_ready`=1 → 4 words with `out_addr` 0,1,2,3; first `out_valid` 3 cycles after `start`; `done` one cycle after the 4th handshake.
- Wrap-around: `start_addr`=30, `count`=4 → `out_addr` sequence 30,31,0,1.
- Backpressure: hold `out_ready`=0 for 5 cycles in HOLD → `out_word` stable, `read_pointer` unchanged, no extra words; release → next word follows.
- `count`=0 → `done` pulse 1 cycle after `start`, `out_valid` never rises. `start` pulsed while `busy` → ignored.
- Checker on (`INSTR_READER_CHECK_EN`):
  - Entry DIV a=12, b=3 with stored result 4 → `chk_err`=0.
  - Same operands with stored result 36 → `chk_err`=1 and `err_cnt`=1.
  - MOD with b=0 and stored result 0 → `chk_err`=0.
